div_16x8_seq: RTL and testbench

DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 19 +
 rtl/div_16x8_seq.sv | 143 ++++++++++++++
 tb/tb_div_16x8_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// the FSM state type and the default operand width.
package div_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW:0]   p,
  input  logic          bit_in,
  input  logic [DW-1:0] b,
  output logic [DW:0]   p_next,
  output logic          q_bit
);

  // p stays below b, so its top bit is zero and the shifted value fits DW+1 bits
  assign q_bit  = ({p, bit_in} >= {2'b00, b});
  assign p_next = q_bit ? ({p[DW-1:0], bit_in} - {1'b0, b}) : {p[DW-1:0], bit_in};

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential 2*DW / DW restoring divider with valid/ready handshakes on
// both sides; overflow and divide-by-zero are resolved on the accept edge.
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] R,
  input  logic [DW-1:0]   B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   Q,
  output logic [DW-1:0]   REM,
  output logic            ovf,
  output logic            dz
);

  localparam int CW = $clog2(DW) + 1;

  state_t          state;
  state_t          state_next;
  logic            ready_reg;
  logic [DW:0]     p;
  logic [DW:0]     p_new;
  logic            q_bit;
  logic [DW-1:0]   lo;
  logic [DW-1:0]   b_reg;
  logic [DW-1:0]   q_reg;
  logic [DW-1:0]   rem_reg;
  logic            ovf_reg;
  logic            dz_reg;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last_step;
  logic            is_error;

  assign accept    = in_valid && ready_reg;
  assign last_step = (cnt == CW'(DW - 1));
  // B==0 is covered too, since the upper half is always >= 0
  assign is_error  = (R[2*DW-1:DW] >= B);

  div_step #(.DW(DW)) u_step (
    .p      (p),
    .bit_in (lo[DW-1]),
    .b      (b_reg),
    .p_next (p_new),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state     <= state_next;
      ready_reg <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = is_error ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      lo      <= '0;
      b_reg   <= '0;
      q_reg   <= '0;
      rem_reg <= '0;
      ovf_reg <= 1'b0;
      dz_reg  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_reg <= B;
            lo    <= R[DW-1:0];
            cnt   <= '0;
            p     <= {1'b0, R[2*DW-1:DW]};
            if (B == '0) begin
              dz_reg  <= 1'b1;
              ovf_reg <= 1'b0;
              q_reg   <= '1;
              rem_reg <= R[DW-1:0];
            end else if (is_error) begin
              dz_reg  <= 1'b0;
              ovf_reg <= 1'b1;
              q_reg   <= '1;
              rem_reg <= '0;
            end else begin
              dz_reg  <= 1'b0;
              ovf_reg <= 1'b0;
              q_reg   <= '0;
              rem_reg <= '0;
            end
          end
        end
        RUN: begin
          p     <= p_new;
          lo    <= {lo[DW-2:0], 1'b0};
          q_reg <= {q_reg[DW-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            rem_reg <= p_new[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (state == DONE);
  assign Q         = q_reg;
  assign REM       = rem_reg;
  assign ovf       = ovf_reg;
  assign dz        = dz_reg;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Randomized self-checking bench for div_16x8_seq against an arithmetic
// reference model (integer / and %), with directed corner cases.
module tb_div_16x8_seq;

  typedef struct {
    logic [7:0] q;
    logic [7:0] rem;
    logic       ovf;
    logic       dz;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] R;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Q;
  logic [7:0]  REM;
  logic        ovf;
  logic        dz;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  div_16x8_seq #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .REM       (REM),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] r, input logic [7:0] b);
    exp_t e;
    int   quo;
    if (b == 8'd0) begin
      e.dz = 1'b1; e.ovf = 1'b0; e.q = 8'hFF; e.rem = r[7:0];
    end else begin
      quo = int'(r) / int'(b);
      if (quo > 255) begin
        e.dz = 1'b0; e.ovf = 1'b1; e.q = 8'hFF; e.rem = 8'h00;
      end else begin
        e.dz = 1'b0; e.ovf = 1'b0; e.q = quo[7:0]; e.rem = 8'(int'(r) % int'(b));
      end
    end
    return e;
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("Q", 32'(Q), 32'(exp_q[0].q));
        checkOutput("REM", 32'(REM), 32'(exp_q[0].rem));
        checkOutput("ovf", 32'(ovf), 32'(exp_q[0].ovf));
        checkOutput("dz", 32'(dz), 32'(exp_q[0].dz));
        checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] r, input logic [7:0] b, input exp_t e, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    R         = r;
    B         = b;
    out_ready = (hold == 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    R        = 16'($urandom);
    B        = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("latency", 32'(lat), (e.dz || e.ovf) ? 32'd1 : 32'd9);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("idle_after_handoff", {30'd0, out_valid, in_ready}, 32'b01);
    end else begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    R         = '0;
    B         = '0;

    e = model(16'h3039, 8'h64);
    checkOutput("model_q_3039", 32'(e.q), 32'h7B);
    checkOutput("model_rem_3039", 32'(e.rem), 32'h2D);
    e = model(16'hFE01, 8'hFF);
    checkOutput("model_q_fe01", 32'(e.q), 32'hFF);
    checkOutput("model_rem_fe01", 32'(e.rem), 32'h00);
    e = model(16'h1000, 8'h10);
    checkOutput("model_ovf_1000", {30'd0, e.ovf, e.dz}, 32'b10);
    e = model(16'h1234, 8'h00);
    checkOutput("model_dz_rem_1234", {23'd0, e.dz, e.rem}, 32'h134);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {20'd0, Q, REM, ovf, dz, out_valid, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed corner cases with literal expectations
    e.q = 8'h7B; e.rem = 8'h2D; e.ovf = 1'b0; e.dz = 1'b0;
    applyStimulus(16'h3039, 8'h64, e, 0);
    e.q = 8'hFF; e.rem = 8'h00; e.ovf = 1'b0; e.dz = 1'b0;
    applyStimulus(16'hFE01, 8'hFF, e, 2);
    e.q = 8'hFF; e.rem = 8'h00; e.ovf = 1'b1; e.dz = 1'b0;
    applyStimulus(16'h1000, 8'h10, e, 0);
    e.q = 8'hFF; e.rem = 8'h34; e.ovf = 1'b0; e.dz = 1'b1;
    applyStimulus(16'h1234, 8'h00, e, 0);
    e.q = 8'h7B; e.rem = 8'h2D; e.ovf = 1'b0; e.dz = 1'b0;
    applyStimulus(16'h3039, 8'h64, e, 5);

    // Reset asserted partway through RUN discards the operation
    in_valid = 1'b1; R = 16'h3039; B = 8'h64;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_outputs", {20'd0, Q, REM, ovf, dz, out_valid, in_ready}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      checkOutput("no_result_after_reset", 32'(out_valid), 32'd0);
    end
    e.q = 8'h7B; e.rem = 8'h2D; e.ovf = 1'b0; e.dz = 1'b0;
    applyStimulus(16'h3039, 8'h64, e, 1);

    // Random operands, biased toward zero divisors and overflowing dividends
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 8'd0;
        1: b = 8'($urandom_range(1, 255)) & r[15:8];
        default: b = 8'($urandom);
      endcase
      applyStimulus(r, b, model(r, b), int'($urandom_range(0, 3)));
    end

    // Round trip through exact 8x8 products
    for (int i = 0; i < 4000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      r = 16'(a * b);
      e.q = a; e.rem = 8'h00; e.ovf = 1'b0; e.dz = 1'b0;
      applyStimulus(r, b, e, 0);
    end

    repeat (3) @(posedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
